// File: rtl/pe_noc_adapter.sv
// PE-to-NoC adapter: TX FIFO builds {dest_y, dest_x, data} flits for the switch,
// RX FIFO accepts flits addressed to this node and flags misroutes/overflows.

module pe_noc_adapter_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic                     o_valid,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] w_rd_nxt;
    logic [LW-1:0] w_level_nxt;

    always_comb begin
        w_rd_nxt    = i_pop ? r_rd + AW'(1) : r_rd;
        w_level_nxt = o_level;
        if (i_push && !i_pop)
            w_level_nxt = o_level + LW'(1);
        else if (!i_push && i_pop)
            w_level_nxt = o_level - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_data;
    end

    // Output register always holds the post-edge head; a push into an empty
    // (or just-drained) FIFO bypasses the memory so latency stays one edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            o_level <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            if (i_push)
                r_wr <= r_wr + AW'(1);
            r_rd    <= w_rd_nxt;
            o_level <= w_level_nxt;
            o_valid <= (w_level_nxt != '0);
            if (w_level_nxt != '0)
                o_data <= (i_push && (r_wr == w_rd_nxt)) ? i_data : r_mem[w_rd_nxt];
        end
    end
endmodule

module pe_noc_adapter #(
    parameter int X           = 4,
    parameter int Y           = 4,
    parameter int data_width  = 256,
    parameter int x_size      = 2,
    parameter int y_size      = 2,
    parameter int total_width = x_size + y_size + data_width,
    parameter int x_coord     = 0,
    parameter int y_coord     = 0,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_tx_valid,
    input  logic [x_size-1:0]        i_tx_dest_x,
    input  logic [y_size-1:0]        i_tx_dest_y,
    input  logic [data_width-1:0]    i_tx_data,
    output logic                     o_tx_ready,
    output logic                     o_noc_valid,
    output logic [total_width-1:0]   o_noc_data,
    input  logic                     i_noc_ready,
    input  logic                     i_noc_valid,
    input  logic [total_width-1:0]   i_noc_data,
    output logic                     o_rx_valid,
    output logic [data_width-1:0]    o_rx_data,
    input  logic                     i_rx_ready,
    output logic                     o_rx_overflow,
    output logic                     o_rx_misroute,
    input  logic                     i_clr_flags,
    output logic [$clog2(DEPTH):0]   o_tx_level,
    output logic [$clog2(DEPTH):0]   o_rx_level
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]     LP_FULL = LW'(DEPTH);
    localparam logic [x_size-1:0] LP_X    = x_size'(x_coord);
    localparam logic [y_size-1:0] LP_Y    = y_size'(y_coord);
    // A node placed outside the mesh can never be addressed.
    localparam bit LP_IN_MESH = (x_coord < X) && (y_coord < Y);

    logic                   w_tx_push;
    logic                   w_tx_pop;
    logic [total_width-1:0] w_tx_flit;
    logic                   w_rx_match;
    logic                   w_rx_full;
    logic                   w_rx_pop;
    logic                   w_rx_push;
    logic                   w_set_ovf;
    logic                   w_set_mis;
    logic [x_size-1:0]      w_rx_dx;
    logic [y_size-1:0]      w_rx_dy;

    always_comb begin
        o_tx_ready = (o_tx_level != LP_FULL);
        w_tx_push  = i_tx_valid && o_tx_ready;
        w_tx_pop   = o_noc_valid && i_noc_ready;
        w_tx_flit  = total_width'({i_tx_dest_y, i_tx_dest_x, i_tx_data});

        w_rx_dx    = i_noc_data[data_width +: x_size];
        w_rx_dy    = i_noc_data[data_width + x_size +: y_size];
        w_rx_match = LP_IN_MESH && (w_rx_dx == LP_X) && (w_rx_dy == LP_Y);
        w_rx_full  = (o_rx_level == LP_FULL);
        w_rx_pop   = o_rx_valid && i_rx_ready;
        w_rx_push  = i_noc_valid && w_rx_match && (!w_rx_full || w_rx_pop);
        w_set_ovf  = i_noc_valid && w_rx_match && w_rx_full && !w_rx_pop;
        w_set_mis  = i_noc_valid && !w_rx_match;
    end

    pe_noc_adapter_fifo #(.W(total_width), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_data  (w_tx_flit),
        .o_valid (o_noc_valid),
        .o_data  (o_noc_data),
        .o_level (o_tx_level)
    );

    pe_noc_adapter_fifo #(.W(data_width), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_data  (i_noc_data[data_width-1:0]),
        .o_valid (o_rx_valid),
        .o_data  (o_rx_data),
        .o_level (o_rx_level)
    );

    // Set events win over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_rx_overflow <= 1'b0;
            o_rx_misroute <= 1'b0;
        end else begin
            if (w_set_ovf)
                o_rx_overflow <= 1'b1;
            else if (i_clr_flags)
                o_rx_overflow <= 1'b0;
            if (w_set_mis)
                o_rx_misroute <= 1'b1;
            else if (i_clr_flags)
                o_rx_misroute <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pe_noc_adapter.sv
// Scoreboard bench for pe_noc_adapter: node (1,2), 16-bit payload, DEPTH 4.
module tb_pe_noc_adapter;
    localparam int DW = 16;
    localparam int TW = DW + 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          tv;
    logic [1:0]    dx, dy;
    logic [DW-1:0] td;
    logic          tready;
    logic          nvalid_o;
    logic [TW-1:0] ndata_o;
    logic          nready;
    logic          nvalid_i;
    logic [TW-1:0] ndata_i;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          rready;
    logic          ovf, mis, clr;
    logic [2:0]    tlvl, rlvl;

    int tests = 0;
    int fails = 0;

    logic [TW-1:0] tx_model[$];
    logic [DW-1:0] rx_model[$];
    logic [TW-1:0] sb_tx[$];
    logic [DW-1:0] sb_rx[$];
    logic          m_ovf = 1'b0;
    logic          m_mis = 1'b0;

    always #5 clk = ~clk;

    pe_noc_adapter #(.data_width(DW), .x_coord(1), .y_coord(2), .DEPTH(D)) dut (
        .clk(clk), .rstn(rstn),
        .i_tx_valid(tv), .i_tx_dest_x(dx), .i_tx_dest_y(dy), .i_tx_data(td),
        .o_tx_ready(tready),
        .o_noc_valid(nvalid_o), .o_noc_data(ndata_o), .i_noc_ready(nready),
        .i_noc_valid(nvalid_i), .i_noc_data(ndata_i),
        .o_rx_valid(rvalid), .o_rx_data(rdata), .i_rx_ready(rready),
        .o_rx_overflow(ovf), .o_rx_misroute(mis), .i_clr_flags(clr),
        .o_tx_level(tlvl), .o_rx_level(rlvl)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (nvalid_o && nready) begin
                if (sb_tx.size() == 0) chk("noc_unexpected", 32'(ndata_o), 32'hDEAD);
                else chk("noc_flit", 32'(ndata_o), 32'(sb_tx.pop_front()));
            end
            if (rvalid && rready) begin
                if (sb_rx.size() == 0) chk("rx_unexpected", 32'(rdata), 32'hDEAD);
                else chk("rx_data", 32'(rdata), 32'(sb_rx.pop_front()));
            end
        end
    end

    // Advance one edge: update the reference model from the held inputs,
    // then check the visible state just after the edge.
    task automatic step();
        int  tn, rn;
        bit  tpop, rpop, match, s_ovf, s_mis;
        @(posedge clk);
        if (!rstn) begin
            tx_model.delete(); rx_model.delete();
            sb_tx.delete();    sb_rx.delete();
            m_ovf = 1'b0; m_mis = 1'b0;
        end else begin
            tn   = tx_model.size();
            tpop = (tn > 0) && nready;
            if (tpop) void'(tx_model.pop_front());
            if (tv && tn < D) begin
                tx_model.push_back({dy, dx, td});
                sb_tx.push_back({dy, dx, td});
            end
            rn    = rx_model.size();
            rpop  = (rn > 0) && rready;
            match = (ndata_i[DW+:2] == 2'd1) && (ndata_i[DW+2+:2] == 2'd2);
            s_ovf = 0; s_mis = 0;
            if (rpop) void'(rx_model.pop_front());
            if (nvalid_i) begin
                if (!match) s_mis = 1;
                else if (rn < D || rpop) begin
                    rx_model.push_back(ndata_i[DW-1:0]);
                    sb_rx.push_back(ndata_i[DW-1:0]);
                end else s_ovf = 1;
            end
            m_ovf = s_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_mis = s_mis ? 1'b1 : (clr ? 1'b0 : m_mis);
        end
        #1;
        chk("tx_level",  32'(tlvl),     32'(tx_model.size()));
        chk("rx_level",  32'(rlvl),     32'(rx_model.size()));
        chk("tx_ready",  32'(tready),   32'(tx_model.size() != D));
        chk("noc_valid", 32'(nvalid_o), 32'(tx_model.size() != 0));
        chk("rx_valid",  32'(rvalid),   32'(rx_model.size() != 0));
        chk("overflow",  32'(ovf),      32'(m_ovf));
        chk("misroute",  32'(mis),      32'(m_mis));
        if (tx_model.size() != 0) chk("noc_head", 32'(ndata_o), 32'(tx_model[0]));
        if (rx_model.size() != 0) chk("rx_head",  32'(rdata),   32'(rx_model[0]));
        if (!rstn) begin
            chk("rst_noc_data", 32'(ndata_o), 32'h0);
            chk("rst_rx_data",  32'(rdata),   32'h0);
        end
    endtask

    task automatic idle();
        tv = 0; nvalid_i = 0; clr = 0;
    endtask

    initial begin
        rstn = 0; tv = 0; dx = 0; dy = 0; td = 0; nready = 0;
        nvalid_i = 0; ndata_i = 0; rready = 0; clr = 0;
        step();
        rstn = 1;

        // Single flit, switch ready.
        tv = 1; dx = 2'd3; dy = 2'd0; td = 16'h00A5; nready = 1;
        step(); idle();
        chk("req035_flit", 32'(ndata_o), 32'h300A5);
        step();
        chk("req035_level", 32'(tlvl), 32'd0);

        // TX backpressure: fifth push refused, head held.
        nready = 0;
        for (int i = 1; i <= 5; i++) begin
            tv = 1; dx = 2'(i); dy = 2'(i + 1); td = 16'(16'h1000 + i);
            step();
            if (i == 4) chk("req036_full", 32'(tready), 32'd0);
        end
        idle(); step();
        chk("req036_head", 32'(ndata_o[DW-1:0]), 32'h1001);
        nready = 1;
        repeat (5) step();

        // RX overflow with PE stalled, then in-order drain.
        rready = 0;
        for (int i = 1; i <= 5; i++) begin
            nvalid_i = 1; ndata_i = {2'd2, 2'd1, 16'(16'h2000 + i)};
            step();
        end
        idle();
        chk("req037_level", 32'(rlvl), 32'd4);
        chk("req037_ovf", 32'(ovf), 32'd1);
        rready = 1;
        repeat (5) step();
        clr = 1; step(); clr = 0;

        // Misroute and flag clear.
        nvalid_i = 1; ndata_i = {2'd0, 2'd0, 16'h3333};
        step(); idle();
        chk("req038_mis", 32'(mis), 32'd1);
        chk("req038_level", 32'(rlvl), 32'd0);
        clr = 1; step(); clr = 0;
        chk("req038_clr", 32'(mis), 32'd0);

        // Full RX with simultaneous pop and arrival.
        rready = 0;
        for (int i = 1; i <= 4; i++) begin
            nvalid_i = 1; ndata_i = {2'd2, 2'd1, 16'(16'h4000 + i)};
            step();
        end
        rready = 1; ndata_i = {2'd2, 2'd1, 16'h4005};
        step(); idle(); rready = 0;
        chk("req039_level", 32'(rlvl), 32'd4);
        chk("req039_ovf", 32'(ovf), 32'd0);
        rready = 1;
        repeat (5) step();

        // Reset with both FIFOs half full.
        nready = 0; rready = 0;
        for (int i = 1; i <= 2; i++) begin
            tv = 1; dx = 2'd1; dy = 2'd1; td = 16'(16'h5000 + i);
            nvalid_i = 1; ndata_i = {2'd2, 2'd1, 16'(16'h6000 + i)};
            step();
        end
        idle();
        rstn = 0; step(); rstn = 1;
        chk("req040_tready", 32'(tready), 32'd1);
        chk("req040_nvalid", 32'(nvalid_o), 32'd0);
        chk("req040_rvalid", 32'(rvalid), 32'd0);
        nready = 1; step();
        chk("req034_noflit", 32'(nvalid_o), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            rstn   = ($urandom_range(0, 299) != 0);
            tv     = ($urandom_range(0, 9) < 7);
            dx     = 2'($urandom); dy = 2'($urandom); td = 16'($urandom);
            nready = ($urandom_range(0, 9) < 6);
            nvalid_i = ($urandom_range(0, 9) < 5);
            if ($urandom_range(0, 9) < 8) ndata_i = {2'd2, 2'd1, 16'($urandom)};
            else ndata_i = TW'($urandom);
            rready = ($urandom_range(0, 9) < 6);
            clr    = ($urandom_range(0, 19) == 0);
            step();
        end

        rstn = 1; idle(); nready = 1; rready = 1;
        repeat (10) step();
        chk("drain_tx", 32'(sb_tx.size()), 32'd0);
        chk("drain_rx", 32'(sb_rx.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pe_noc_adapter.md
PE_NOC_ADAPTER -- requirements
Module: pe_noc_adapter

Interface
REQ-001 SHALL have parameter X, default 4, mesh columns.
REQ-002 SHALL have parameter Y, default 4, mesh rows.
REQ-003 SHALL have parameter data_width, default 256, payload bits.
REQ-004 SHALL have parameters x_size and y_size, default 2 each, destination coordinate widths.
REQ-005 SHALL have parameter total_width, default x_size+y_size+data_width, NoC flit width.
REQ-006 SHALL have parameters x_coord and y_coord, default 0 each, the attached switch's coordinates.
REQ-007 SHALL have parameter DEPTH, default 4, FIFO depth per direction; power of 2, at least 2.
REQ-008 SHALL have port clk, input, 1 bit; the single clock, with all logic on its rising edge.
REQ-009 SHALL have port rstn, input, 1 bit; reset is synchronous and active-low.
REQ-010 SHALL have port i_tx_valid, input, 1 bit; PE transmit request.
REQ-011 SHALL have ports i_tx_dest_x (input, x_size bits) and i_tx_dest_y (input, y_size bits); destination coordinates.
REQ-012 SHALL have port i_tx_data, input, data_width bits; transmit payload.
REQ-013 SHALL have port o_tx_ready, input-side handshake output, 1 bit; TX FIFO can accept.
REQ-014 SHALL have ports o_noc_valid (output, 1 bit) and o_noc_data (output, total_width bits); flit to switch PE input.
REQ-015 SHALL have port i_noc_ready, input, 1 bit; switch accepts flit.
REQ-016 SHALL have ports i_noc_valid (input, 1 bit) and i_noc_data (input, total_width bits); flit from switch PE output, no backpressure.
REQ-017 SHALL have ports o_rx_valid (output, 1 bit) and o_rx_data (output, data_width bits); received payload to PE.
REQ-018 SHALL have port i_rx_ready, input, 1 bit; PE consumes received payload.
REQ-019 SHALL have ports o_rx_overflow and o_rx_misroute, outputs, 1 bit each; sticky error flags.
REQ-020 SHALL have port i_clr_flags, input, 1 bit; clears the sticky error flags.
REQ-021 SHALL have ports o_tx_level and o_rx_level, outputs, $clog2(DEPTH)+1 bits each; FIFO occupancy.

Function
REQ-022 SHALL build each flit as {dest_y, dest_x, data}: data in [data_width-1:0], dest_x directly above it, dest_y in the MSBs.
REQ-023 SHALL drive o_tx_ready = (tx_level != DEPTH); a push is accepted when i_tx_valid and o_tx_ready are both high, and a pop in the same cycle does not admit a push when full.
REQ-024 SHALL register the head of the TX FIFO onto o_noc_valid/o_noc_data; first-word latency is 1 cycle after the accepting push edge.
REQ-025 SHALL pop the TX FIFO on o_noc_valid and i_noc_ready; o_noc_data SHALL remain stable while o_noc_valid is high and i_noc_ready is low.
REQ-026 SHALL sustain one flit per cycle in each direction when neither side stalls.
REQ-027 SHALL compare an incoming flit's dest field with (x_coord, y_coord): on a match, write data to the RX FIFO; on a mismatch, discard the flit and set o_rx_misroute.
REQ-028 SHALL, when a matching flit arrives with the RX FIFO full: accept it if a PE pop (o_rx_valid and i_rx_ready) occurs the same cycle; otherwise discard it and set o_rx_overflow.
REQ-029 SHALL present the RX head on o_rx_valid/o_rx_data registered, with 1 cycle of latency from the write edge, holding it stable until popped.
REQ-030 SHALL wrap FIFO read and write pointers modulo DEPTH; level updates are +1 for push only, -1 for pop only, and unchanged for both or neither.
REQ-031 SHALL let i_clr_flags clear both sticky flags, with a set event in the same cycle taking priority over the clear.
REQ-032 SHALL not reorder flits; FIFO order is preserved in both directions.

Reset
REQ-033 SHALL, when rstn is low at a clock edge, set o_tx_ready=1, o_noc_valid=0, o_noc_data=0, o_rx_valid=0, o_rx_data=0, both levels=0, and both flags=0.
REQ-034 SHALL discard FIFO contents on reset mid-transfer, with no flit emitted on the cycle after reset.

Verification
REQ-035 SHALL pass the following check: with x_coord=1, y_coord=2, push dest (3,0) and data 0xA5 while i_noc_ready=1 -> next cycle o_noc_valid=1 and o_noc_data={2'd0,2'd3,0xA5}, and tx_level returns to 0.
REQ-036 SHALL pass the following check: hold i_noc_ready=0 and push 5 words with DEPTH=4 -> o_tx_ready=0 after the 4th push, the 5th is not accepted, and o_noc_data stays at word 1.
REQ-037 SHALL pass the following check: hold i_rx_ready=0 and send 5 matching flits -> o_rx_level=4 and o_rx_overflow=1, and popping returns words 1-4 in order.
REQ-038 SHALL pass the following check: send a flit with dest (0,0) to the node at (1,2) -> no RX write and o_rx_misroute=1; pulse i_clr_flags -> the flag returns to 0.
REQ-039 SHALL pass the following check: with the RX FIFO full, a matching flit arrives on the same cycle as a PE pop -> it is accepted, o_rx_level stays 4, and no overflow is flagged.
REQ-040 SHALL pass the following check: assert rstn=0 for 1 cycle with both FIFOs half full -> all outputs match the REQ-033 values on the next edge.
